// File: rtl/rcosc_req_ctrl_if.sv
// rcosc_req_ctrl_if -- request/grant bundle between fabric clients and the
// RC oscillator sequencer.
//   REQ         client -> ctrl  per-client clock request (level)
//   ACK         ctrl -> client  per-client grant, global 160 MHz clock valid
//   OSC_ON      ctrl -> pad     oscillator enable (OSC_160MHZ_ON)
//   CLK_GATE_EN ctrl -> buffer  gated global clock buffer enable
//   OSC_READY   ctrl -> fabric  oscillator up and gate open
//   STATE       ctrl -> debug   FSM state code
//   ON_CNT      ctrl -> debug   OFF->STARTUP count (RCOSC_CTRL_STATS_EN only)
// Modports: master = client side, slave = controller side.
interface rcosc_req_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] REQ;
  logic [NUM_REQ-1:0] ACK;
  logic               OSC_ON;
  logic               CLK_GATE_EN;
  logic               OSC_READY;
  logic [2:0]         STATE;
`ifdef RCOSC_CTRL_STATS_EN
  logic [15:0]        ON_CNT;
`endif

  modport master (
    output REQ,
    input  ACK, OSC_ON, CLK_GATE_EN, OSC_READY, STATE
`ifdef RCOSC_CTRL_STATS_EN
    , input ON_CNT
`endif
  );

  modport slave (
    input  REQ,
    output ACK, OSC_ON, CLK_GATE_EN, OSC_READY, STATE
`ifdef RCOSC_CTRL_STATS_EN
    , output ON_CNT
`endif
  );
endinterface

// File: rtl/rcosc_req_ctrl.sv
// rcosc_req_ctrl -- demand-driven sequencer for the 160 MHz RC oscillator and
// its global clock gate. Runs on the always-on fabric clock.
// Ports:
//   CLK     always-on fabric clock
//   RESETN  synchronous active-low reset
//   bus     rcosc_req_ctrl_if.slave (REQ in; ACK, OSC_ON, CLK_GATE_EN,
//           OSC_READY, STATE out; ON_CNT out when stats enabled)
// Optional feature: define RCOSC_CTRL_STATS_EN to add the saturating ON_CNT
// counter of OFF->STARTUP transitions.
// Sequence: OFF -> STARTUP (osc on, wait) -> ON (gate open, ACK follows REQ)
// -> HOLD (idle timer) -> SHUTDOWN (gate closed, osc still on) -> OFF.
module rcosc_req_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int STARTUP_CYCLES = 64,
  parameter int HOLD_CYCLES    = 256,
  parameter int GATE_LEAD      = 4
) (
  input logic              CLK,
  input logic              RESETN,
  rcosc_req_ctrl_if.slave  bus
);
  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_STARTUP  = 3'd1;
  localparam logic [2:0] S_ON       = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_SHUTDOWN = 3'd4;

  localparam int MAX_SH = (STARTUP_CYCLES > HOLD_CYCLES) ? STARTUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_SH > GATE_LEAD) ? MAX_SH : GATE_LEAD;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LD_STARTUP = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_LEAD    = CW'(GATE_LEAD - 1);

  logic [2:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_osc_on;
  logic               r_gate;
  logic               r_ready;
  logic [NUM_REQ-1:0] r_ack;
  logic               w_any_req;
  logic               w_cnt_zero;

  assign w_any_req  = |bus.REQ;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_osc_on <= 1'b0;
      r_gate   <= 1'b0;
      r_ready  <= 1'b0;
      r_ack    <= '0;
    end else begin
      // ACK is only ever non-zero while ON; every other path clears it.
      r_ack <= '0;
      case (r_state)
        S_OFF: begin
          if (w_any_req) begin
            r_state  <= S_STARTUP;
            r_osc_on <= 1'b1;
            r_cnt    <= LD_STARTUP;
          end
        end
        S_STARTUP: begin
          if (w_cnt_zero) begin
            r_gate  <= 1'b1;
            r_ready <= 1'b1;
            // Startup never aborts; a request that went away lands in HOLD.
            if (w_any_req) begin
              r_state <= S_ON;
            end else begin
              r_state <= S_HOLD;
              r_cnt   <= LD_HOLD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ON: begin
          if (w_any_req) begin
            r_ack <= bus.REQ;
          end else begin
            r_state <= S_HOLD;
            r_cnt   <= LD_HOLD;
          end
        end
        S_HOLD: begin
          // A new request wins over timer expiry on the same edge.
          if (w_any_req) begin
            r_state <= S_ON;
          end else if (w_cnt_zero) begin
            r_state <= S_SHUTDOWN;
            r_gate  <= 1'b0;
            r_ready <= 1'b0;
            r_cnt   <= LD_LEAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SHUTDOWN: begin
          // Gate is already closed; the oscillator drops GATE_LEAD cycles later.
          if (w_cnt_zero) begin
            r_state  <= S_OFF;
            r_osc_on <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= S_OFF;
          r_cnt    <= '0;
          r_osc_on <= 1'b0;
          r_gate   <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK         = r_ack;
  assign bus.OSC_ON      = r_osc_on;
  assign bus.CLK_GATE_EN = r_gate;
  assign bus.OSC_READY   = r_ready;
  assign bus.STATE       = r_state;

`ifdef RCOSC_CTRL_STATS_EN
  logic [15:0] r_on_cnt;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_on_cnt <= '0;
    end else if (r_state == S_OFF && w_any_req && r_on_cnt != 16'hFFFF) begin
      r_on_cnt <= r_on_cnt + 16'd1;
    end
  end

  assign bus.ON_CNT = r_on_cnt;
`endif
endmodule

// File: tb/tb_rcosc_req_ctrl.sv
module tb_rcosc_req_ctrl;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic ack_seen = 1'b0;
  logic osc_dropped = 1'b0;
  logic [3:0] prev_ack = '0;

  always #5 clk = ~clk;

  rcosc_req_ctrl_if #(.NUM_REQ(4)) bus ();

  rcosc_req_ctrl #(
    .NUM_REQ(4), .STARTUP_CYCLES(8), .HOLD_CYCLES(16), .GATE_LEAD(2)
  ) dut (
    .CLK    (clk),
    .RESETN (rstn),
    .bus    (bus.slave)
  );

  // Invariant monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      assert (!bus.CLK_GATE_EN || bus.OSC_ON) else $error("invariant: gate without osc");
      assert (bus.ACK == 4'b0 || bus.OSC_READY) else $error("invariant: ack without ready");
      assert ((bus.ACK & ~prev_ack) == 4'b0 || bus.STATE == 3'd2)
        else $error("invariant: ack rose outside ON");
    end
    if (|bus.ACK) ack_seen = 1'b1;
    if (!bus.OSC_ON) osc_dropped = 1'b1;
    prev_ack = bus.ACK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic osc,
                         input logic gate, input logic rdy, input logic [3:0] ack);
    chk({tag, ".state"}, 32'(bus.STATE), 32'(st));
    chk({tag, ".osc"},   32'(bus.OSC_ON), 32'(osc));
    chk({tag, ".gate"},  32'(bus.CLK_GATE_EN), 32'(gate));
    chk({tag, ".rdy"},   32'(bus.OSC_READY), 32'(rdy));
    chk({tag, ".ack"},   32'(bus.ACK), 32'(ack));
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef RCOSC_CTRL_STATS_EN
  task automatic run_cycle();
    bus.REQ = 4'b0001;
    tick(1);            // OFF -> STARTUP
    bus.REQ = 4'b0000;
    tick(8 + 16 + 2);   // STARTUP -> HOLD -> SHUTDOWN -> OFF
  endtask
`endif

  initial begin
    bus.REQ = 4'b0000;
    rstn    = 1'b0;

    // 1. reset and first request
    tick(2);
    chk_out("rst", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    rstn = 1'b1;
    tick(1);
    chk_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bus.REQ = 4'b0001;
    tick(1);                          // edge k
    chk_out("t1.k", 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick(7);                          // edge k+7
    chk_out("t1.k7", 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick(1);                          // edge k+8
    chk_out("t1.k8", 3'd2, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick(1);                          // edge k+9
    chk_out("t1.k9", 3'd2, 1'b1, 1'b1, 1'b1, 4'b0001);

    // 2. drop request, hold 16, gate lead 2
    bus.REQ = 4'b0000;
    tick(1);
    chk_out("t2.drop", 3'd3, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick(15);
    chk_out("t2.h15", 3'd3, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick(1);
    chk_out("t2.shut", 3'd4, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick(1);
    chk_out("t2.lead", 3'd4, 1'b1, 1'b0, 1'b0, 4'b0000);
    tick(1);
    chk_out("t2.off", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 3. re-request during HOLD, 5 cycles before expiry
    bus.REQ = 4'b0001;
    tick(9);                          // k .. k+8 -> ON
    chk("t3.on", 32'(bus.STATE), 32'd2);
    bus.REQ = 4'b0000;
    tick(1);                          // HOLD, count 15
    osc_dropped = 1'b0;
    tick(11);                         // count 4
    bus.REQ = 4'b0100;
    tick(1);
    chk_out("t3.reon", 3'd2, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick(1);
    chk_out("t3.ack", 3'd2, 1'b1, 1'b1, 1'b1, 4'b0100);
    chk("t3.osc_kept", 32'(osc_dropped), 32'd0);

    // 3b. request on the exact expiry edge takes priority
    bus.REQ = 4'b0000;
    tick(16);                         // HOLD entered, 15 more edges: count 0
    chk("t3b.hold", 32'(bus.STATE), 32'd3);
    bus.REQ = 4'b1000;
    tick(1);
    chk_out("t3b.prio", 3'd2, 1'b1, 1'b1, 1'b1, 4'b0000);

    // back to OFF
    bus.REQ = 4'b0000;
    tick(1 + 16 + 2);
    chk("t3b.off", 32'(bus.STATE), 32'd0);

    // 4. 3-cycle pulse: full startup, then HOLD, no ACK ever
    ack_seen = 1'b0;
    bus.REQ = 4'b0010;
    tick(3);                          // k, k+1, k+2 sample REQ
    bus.REQ = 4'b0000;
    tick(4);                          // k+6
    chk("t4.k6", 32'(bus.STATE), 32'd1);
    tick(2);                          // k+8
    chk_out("t4.hold", 3'd3, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick(15);
    chk("t4.h15", 32'(bus.STATE), 32'd3);
    tick(1);                          // k+24
    chk_out("t4.shut", 3'd4, 1'b1, 1'b0, 1'b0, 4'b0000);
    bus.REQ = 4'b1000;                // ignored in SHUTDOWN
    tick(1);
    chk("t4.ign", 32'(bus.STATE), 32'd4);
    tick(1);                          // k+26
    chk_out("t4.off", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("t4.noack", 32'(ack_seen), 32'd0);
    tick(1);                          // REQ still high restarts
    chk_out("t4.restart", 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000);

    // 5. reset while ON with all ACKs
    bus.REQ = 4'b1111;
    tick(8);
    tick(1);
    chk_out("t5.ack", 3'd2, 1'b1, 1'b1, 1'b1, 4'b1111);
    rstn = 1'b0;
    tick(1);
    chk_out("t5.rst", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bus.REQ = 4'b0000;
    rstn = 1'b1;
    tick(2);
    chk_out("t5.idle", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

`ifdef RCOSC_CTRL_STATS_EN
    // 6. transition counter and saturation
    rstn = 1'b0;
    tick(1);
    chk("t6.rst", 32'(bus.ON_CNT), 32'd0);
    rstn = 1'b1;
    tick(1);
    run_cycle();
    run_cycle();
    run_cycle();
    chk("t6.cnt3", 32'(bus.ON_CNT), 32'd3);
    force dut.r_on_cnt = 16'hFFFF;
    #1;
    release dut.r_on_cnt;
    run_cycle();
    chk("t6.sat", 32'(bus.ON_CNT), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
